seq_alu: RTL and testbench

- Execution stage sitting directly downstream of the 8x8 register file.
- Consumes the two register read ports (OUT1 -> DATA1, OUT2 -> DATA2) and returns a registered RESULT that feeds the register file write-data input.
- Single-cycle logic/arith ops complete in one clock. Multiply and shift/rotate are iterative, with a START/BUSY/DONE handshake so the control unit can stall the PC.

---
 rtl/seq_alu.sv | 120 ++++++++++++
 tb/tb_seq_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Execution stage behind the register file: single-cycle FWD/ADD/AND/OR,
// iterative shift-add MULT and one-bit-per-cycle SLL/SRA/ROR with START/BUSY/DONE.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             START,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [2:0] {
    OP_FWD  = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_MULT = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRA  = 3'b110,
    OP_ROR  = 3'b111
  } op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  op_t              sel_op;
  logic             is_iter;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] acc_step;

  always_comb begin
    sel_op    = op_t'(SELECT);
    quick_res = DATA1;
    case (sel_op)
      OP_FWD:  quick_res = DATA2;
      OP_ADD:  quick_res = DATA1 + DATA2;
      OP_AND:  quick_res = DATA1 & DATA2;
      OP_OR:   quick_res = DATA1 | DATA2;
      default: quick_res = DATA1;  // zero-length shift passes DATA1 through
    endcase
    is_iter = (sel_op == OP_MULT) ||
              ((sel_op inside {OP_SLL, OP_SRA, OP_ROR}) && (DATA2[2:0] != 3'd0));
  end

  always_comb begin
    acc_step = acc;
    case (op)
      OP_MULT: acc_step = mplier[0] ? acc + mcand : acc;
      OP_SLL:  acc_step = {acc[WIDTH-2:0], 1'b0};
      OP_SRA:  acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_ROR:  acc_step = {acc[0], acc[WIDTH-1:1]};
      default: acc_step = acc;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      op     <= OP_FWD;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      RESULT <= '0;
      ZERO   <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op <= sel_op;
            if (is_iter) begin
              state  <= EXEC;
              BUSY   <= 1'b1;
              acc    <= (sel_op == OP_MULT) ? '0 : DATA1;
              mcand  <= DATA1;
              mplier <= DATA2;
              count  <= (sel_op == OP_MULT) ? CW'(WIDTH) : CW'(DATA2[2:0]);
            end else begin
              RESULT <= quick_res;
              ZERO   <= (quick_res == '0);
              DONE   <= 1'b1;
            end
          end
        end
        EXEC: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          // count==1 here means this edge performs the final iteration
          if (count == CW'(1)) begin
            RESULT <= acc_step;
            ZERO   <= (acc_step == '0);
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: scoreboard of expected results popped on DONE,
// plus per-scenario latency/handshake checks.
module tb_seq_alu;

  logic       CLK;
  logic       RESET;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] SELECT;
  logic       START;
  logic [7:0] RESULT;
  logic       ZERO;
  logic       BUSY;
  logic       DONE;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  sb_q[$];

  seq_alu #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .START(START), .RESULT(RESULT), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] model(input logic [2:0] sel, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] prod;
    logic [15:0] dbl;
    int unsigned n;
    n = int'(b[2:0]);
    prod = 16'(a) * 16'(b);
    dbl = {a, a} >> n;
    case (sel)
      3'd0: return b;
      3'd1: return a + b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return prod[7:0];
      3'd5: return a << n;
      3'd6: return 8'($signed(a) >>> n);
      default: return dbl[7:0];
    endcase
  endfunction

  function automatic int unsigned latency(input logic [2:0] sel, input logic [7:0] b);
    if (sel == 3'd4) return 8;
    if (sel >= 3'd5) return int'(b[2:0]);
    return 0;
  endfunction

  // Scoreboard consumer: every DONE must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && DONE === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_done RESULT=%h with no outstanding request", RESULT);
      end else begin
        logic [7:0] exp;
        exp = sb_q.pop_front();
        if (RESULT !== exp || ZERO !== (exp == 8'h00)) begin
          errors++;
          $display("FAIL sb_result got RESULT=%h ZERO=%b expected RESULT=%h ZERO=%b",
                   RESULT, ZERO, exp, (exp == 8'h00));
        end
      end
    end
    if (BUSY === 1'b1 && DONE === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_while_busy got DONE=1 BUSY=1 expected DONE=0");
    end
  end

  // Issues one op at the current time; checks BUSY/DONE each cycle up to completion.
  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    int unsigned lat;
    lat = latency(sel, b);
    sb_q.push_back(model(sel, a, b));
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    DATA1 = ~a; DATA2 = ~b; SELECT = ~sel;
    for (int unsigned i = 1; i <= lat; i++) begin
      checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        errors++;
        $display("FAIL run_busy sel=%0d cycle %0d got BUSY=%b DONE=%b expected BUSY=1 DONE=0",
                 sel, i - 1, BUSY, DONE);
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL run_done sel=%0d after %0d edges got DONE=%b BUSY=%b expected DONE=1 BUSY=0",
               sel, lat, DONE, BUSY);
    end
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL idle got DONE=%b BUSY=%b expected DONE=0 BUSY=0", DONE, BUSY);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; DATA1 = '0; DATA2 = '0; SELECT = '0;
    #3 RESET = 1'b0;
    #1;
    checks++;
    if (RESULT !== 8'h00 || ZERO !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset got RESULT=%h ZERO=%b BUSY=%b DONE=%b expected 00 1 0 0",
               RESULT, ZERO, BUSY, DONE);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_single_cycle();
    run_op(3'd1, 8'd5, 8'd3);
    idle_cycle();
    run_op(3'd2, 8'hF0, 8'h0F);
    idle_cycle();
    run_op(3'd0, 8'h11, 8'h5A);
    run_op(3'd3, 8'hA0, 8'h05);
    idle_cycle();
  endtask

  task automatic test_mult();
    run_op(3'd4, 8'd12, 8'd11);
    idle_cycle();
    run_op(3'd4, 8'd20, 8'd13);
    idle_cycle();
    run_op(3'd4, 8'hFF, 8'hFF);
    idle_cycle();
  endtask

  task automatic test_shifts();
    run_op(3'd6, 8'h90, 8'd3);
    idle_cycle();
    run_op(3'd7, 8'h81, 8'd1);
    idle_cycle();
    run_op(3'd5, 8'hA5, 8'd0);
    idle_cycle();
    run_op(3'd5, 8'h81, 8'd7);
    run_op(3'd6, 8'h40, 8'd2);
    idle_cycle();
  endtask

  task automatic test_start_while_busy();
    sb_q.push_back(8'h84);
    SELECT = 3'd4; DATA1 = 8'd12; DATA2 = 8'd11; START = 1'b1;
    @(posedge CLK); #1;       // edge k
    START = 1'b0;
    @(posedge CLK); #1;       // edge k+1
    SELECT = 3'd1; DATA1 = 8'd1; DATA2 = 8'd1; START = 1'b1;
    @(posedge CLK); #1;       // edge k+2: must be ignored
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;                       // after edge k+7
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy k+7 got BUSY=%b DONE=%b expected BUSY=1 DONE=0", BUSY, DONE);
    end
    @(posedge CLK); #1;       // edge k+8
    checks++;
    if (DONE !== 1'b1 || RESULT !== 8'h84) begin
      errors++;
      $display("FAIL ignore_done k+8 got DONE=%b RESULT=%h expected DONE=1 RESULT=84", DONE, RESULT);
    end
    repeat (3) idle_cycle();
  endtask

  task automatic test_reset_abort();
    sb_q.push_back(8'h84);
    SELECT = 3'd4; DATA1 = 8'd12; DATA2 = 8'd11; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #3 RESET = 1'b0;          // between edges k+4 and k+5
    #1;
    checks++;
    if (RESULT !== 8'h00 || ZERO !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got RESULT=%h ZERO=%b BUSY=%b DONE=%b expected 00 1 0 0",
               RESULT, ZERO, BUSY, DONE);
    end
    sb_q.delete();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (6) idle_cycle();  // aborted op must never complete
    run_op(3'd1, 8'd2, 8'd2);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < 12; i++) begin
      logic [2:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      sel = 3'($urandom_range(0, 7));
      a   = 8'($urandom);
      b   = 8'($urandom);
      run_op(sel, a, b);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mult();
    test_shifts();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d outstanding results expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
